// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access size, fault codes,
// FSM states, request payload and byte-lane write-enable mask.
package data_mem_pkg;

  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_SIZE  = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_RANGE = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] lane;
    err_e       err;
  } req_info_t;

  // Little-endian lane enables for a store of the given size at byte offset lane.
  function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension of a stored 32-bit word.
module dmem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = 8'(word_i >> {lane_i, 3'b000});
    half_sel  = lane_i[1] ? word_i[31:16] : word_i[15:0];
    rdata_c_o = word_i;
    case (size_i)
      SZ_BYTE: rdata_c_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_c_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: rdata_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory: byte/half/word loads and stores behind a valid/ready request,
// configurable response latency and registered alignment/range/size fault reporting.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_code
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, valid_q;
  logic                  accept, enter_resp;
  logic                  below_base;
  logic [31:0]           off;
  err_e                  err_c;
  req_info_t             req_c, req_q, cur;
  logic [IDX_W-1:0]      idx_c, idx_q, cur_idx;
  logic [31:0]           word_q;
  logic [1:0]            rsp_lane_q, rsp_size_q;
  logic                  rsp_sgn_q;
  err_e                  rsp_err_q;
  logic [3:0]            be;
  logic [31:0]           wlanes;
  logic [31:0]           mem [DEPTH_WORDS];

  // Fault classification of the presented request, highest priority first.
  always_comb begin
    {below_base, off} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    err_c = ERR_NONE;
    if (req_size == 2'b11) begin
      err_c = ERR_SIZE;
    end else if ((req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
      err_c = ERR_ALIGN;
    end else if (below_base || off[31:2] >= 30'(DEPTH_WORDS)) begin
      err_c = ERR_RANGE;
    end
    req_c = '{write: req_write, size: req_size, sgn: req_signed, lane: off[1:0], err: err_c};
    idx_c = off[IDX_W+1:2];
  end

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the response is formed from the live request at the accept edge.
  assign cur        = (state_q == S_WAIT) ? req_q : req_c;
  assign cur_idx    = (state_q == S_WAIT) ? idx_q : idx_c;
  assign enter_resp = (state_d == S_RESP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      req_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      rsp_lane_q <= '0;
      rsp_size_q <= '0;
      rsp_sgn_q  <= 1'b0;
      rsp_err_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != S_WAIT);
      valid_q <= enter_resp;
      if (accept) begin
        req_q <= req_c;
        idx_q <= idx_c;
      end
      if (enter_resp) begin
        word_q     <= (cur.write || cur.err != ERR_NONE) ? '0 : mem[cur_idx];
        rsp_lane_q <= cur.lane;
        rsp_size_q <= cur.size;
        rsp_sgn_q  <= cur.sgn;
        rsp_err_q  <= cur.err;
      end
    end
  end

  // Store path: right-justified data replicated across lanes, committed at accept.
  always_comb begin
    be = (accept && req_write && err_c == ERR_NONE) ? byte_en(req_size, off[1:0]) : 4'b0000;
    case (req_size)
      SZ_BYTE: wlanes = {4{req_wdata[7:0]}};
      SZ_HALF: wlanes = {2{req_wdata[15:0]}};
      default: wlanes = req_wdata;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx_c][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  dmem_load_align u_align (
    .word_i    (word_q),
    .lane_i    (rsp_lane_q),
    .size_i    (rsp_size_q),
    .signed_i  (rsp_sgn_q),
    .rdata_c_o (rsp_rdata)
  );

  assign req_ready    = ready_q;
  assign rsp_valid    = valid_q;
  assign rsp_err      = (rsp_err_q != ERR_NONE);
  assign rsp_err_code = rsp_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, reset-in-flight sequence, randomized
// traffic against a byte-array memory model, and a response-latency sweep over wait states.
module tb_data_mem_unit;

  localparam int W = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err_code;

  logic        sw_valid;
  logic        sw_ready  [4];
  logic        sw_rvalid [4];
  logic [31:0] sw_rdata  [4];
  logic        sw_err    [4];
  logic [1:0]  sw_code   [4];

  int tests = 0;
  int fails = 0;

  logic [7:0] bmem [1024];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  data_mem_unit #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(W)) u_dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_err_code(rsp_err_code)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    data_mem_unit #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(g)) u_sw (
      .clock(clock), .reset_n(reset_n), .req_valid(sw_valid), .req_ready(sw_ready[g]),
      .req_write(1'b0), .req_size(2'b10), .req_signed(1'b0),
      .req_addr(32'h4), .req_wdata(32'h0), .rsp_valid(sw_rvalid[g]),
      .rsp_rdata(sw_rdata[g]), .rsp_err(sw_err[g]), .rsp_err_code(sw_code[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One request: present at a negedge, wait (bounded) for acceptance, then measure latency.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic [1:0] code,
                        output int lat);
    int waitc;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    lat = 0;
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept timeout: req_ready still 0 after %0d cycles", waitc);
      req_valid = 1'b0;
      rd = '0; er = 1'b0; code = '0;
      return;
    end
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clock); #1;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    rd = rsp_rdata; er = rsp_err; code = rsp_err_code;
  endtask

  function automatic logic [1:0] model_err(logic [1:0] sz, logic [31:0] a);
    int n;
    if (sz == 2'd3) return 2'd1;
    n = 1 << sz;
    if (a % n != 0) return 2'd2;
    if (a >= 32'd1024) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic sg);
    int n = 1 << sz;
    longint v = 0;
    for (int b = 0; b < n; b++) v += longint'(bmem[a + b]) << (8 * b);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic model_store(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int n = 1 << sz;
    for (int b = 0; b < n; b++) bmem[a + b] = 8'(wd >> (8 * b));
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, wr, sg;
    logic [1:0]  code, exp_code, sz;
    int          lat, nval;
    logic [7:0]  hist [4];
    logic        pend [4];
    int          acc_n [4];
    int          rsp_n [4];

    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; sw_valid = 1'b0;

    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h010, 32'h8899AABB, 32'h00000000, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h011, 32'h0,        32'h000000AA, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'hFFFFFF88, 2'd0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'hFFFF8899, 2'd0});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'h00008899, 2'd0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h010, 32'h0,        32'hFFFFFFBB, 2'd0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h020, 32'h11223344, 32'h00000000, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h022, 32'hFFFFFF5A, 32'h00000000, 2'd0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h115A3344, 2'd0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h006, 32'h0,        32'h00000000, 2'd2});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h000, 32'hA5A5A5A5, 32'h00000000, 2'd0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h003, 32'h00001234, 32'h00000000, 2'd2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 2'd0});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h040, 32'h0,        32'h00000000, 2'd1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h000, 32'h0,        32'h00000000, 2'd1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 2'd0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h00000000, 2'd3});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEADBEEF, 32'h00000000, 2'd0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'hDEADBEEF, 2'd0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h3FD, 32'h0,        32'h00000000, 2'd2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h400, 32'h0,        32'h00000000, 2'd3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'hDEADBEEF, 2'd0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h002, 32'h0000BEEF, 32'h00000000, 2'd0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hBEEFA5A5, 2'd0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h002, 32'h0,        32'hFFFFBEEF, 2'd0});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h000, 32'h0,        32'h0000A5A5, 2'd0});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h401, 32'h0,        32'h00000000, 2'd1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h402, 32'h0,        32'h00000000, 2'd2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0,        32'hFFFFFFDE, 2'd0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h400, 32'h0,        32'h00000000, 2'd3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 2'd3});

    repeat (3) @(negedge clock);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_err_code", 32'(rsp_err_code), 32'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, rd, er, code, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(1 + W));
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err_code", i), 32'(code), 32'(tbl[i].exp_code));
      chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_code != 2'd0));
    end

    // Reset while a load sits in WAIT: response is dropped, committed stores survive.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("wait req_ready", 32'(req_ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset req_ready", 32'(req_ready), 32'd1);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    nval = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (rsp_valid) nval++;
    end
    chk("post-reset spurious responses", 32'(nval), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, code, lat);
    chk("post-reset lw 0x10", rd, 32'h8899AABB);

    // Fill the whole memory so the byte model is fully known, then random traffic.
    for (int wi = 0; wi < 256; wi++) begin
      wd = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'(wi * 4), wd, rd, er, code, lat);
      model_store(32'(wi * 4), 2'd2, wd);
      chk($sformatf("fill%0d code", wi), 32'(code), 32'd0);
    end
    for (int t = 0; t < 400; t++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 1060));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~(32'(1 << sz) - 32'd1);
      wd = $urandom;
      exp_code = model_err(sz, a);
      exp_rd   = (wr || exp_code != 2'd0) ? 32'd0 : model_load(a, sz, sg);
      do_req(wr, sz, sg, a, wd, rd, er, code, lat);
      if (wr && exp_code == 2'd0) model_store(a, sz, wd);
      chk($sformatf("rnd%0d latency", t), 32'(lat), 32'(1 + W));
      chk($sformatf("rnd%0d rdata a=%h sz=%0d", t, a, sz), rd, exp_rd);
      chk($sformatf("rnd%0d err_code", t), 32'(code), 32'(exp_code));
      chk($sformatf("rnd%0d err", t), 32'(er), 32'(exp_code != 2'd0));
    end

    // Back-to-back loads held valid on instances with 0..3 wait states.
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0; pend[i] = 1'b0; acc_n[i] = 0; rsp_n[i] = 0;
    end
    @(negedge clock);
    sw_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 30) sw_valid = 1'b0;
      for (int i = 0; i < 4; i++) pend[i] = sw_valid && sw_ready[i];
      if (sw_valid) chk($sformatf("sweep w0 ready c%0d", c), 32'(sw_ready[0]), 32'd1);
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        hist[i] = {hist[i][6:0], pend[i]};
        if (pend[i]) acc_n[i]++;
        if (sw_rvalid[i]) rsp_n[i]++;
        chk($sformatf("sweep w%0d c%0d rsp_valid", i, c), 32'(sw_rvalid[i]), 32'(hist[i][i]));
        if (sw_rvalid[i]) chk($sformatf("sweep w%0d c%0d err", i, c), 32'(sw_err[i]), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sweep w%0d responses vs accepts", i), 32'(rsp_n[i]), 32'(acc_n[i]));
    end
    chk("sweep w0 accepts", 32'(acc_n[0]), 32'd30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
